// File: rtl/freq_meter.sv
// Frequency and period meter for a slow asynchronous signal sampled on clock_in.
// Counts rising edges per fixed gate window and measures cycles between consecutive edges.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PER_W       = 32
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [PER_W-1:0]  PER_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_gate_end;
    logic               r_s1, r_s2, r_s3;
    logic               w_edge;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]   w_edge_next;
    logic               w_sat_hit;
    logic               r_sat;
    logic [CNT_W-1:0]   r_freq_out;
    logic               r_freq_valid;
    logic               r_overflow;
    logic               r_busy;
    logic [PER_W-1:0]   r_per_cnt;
    logic               r_armed;
    logic [PER_W-1:0]   r_period_out;
    logic               r_period_valid;

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

    // Saturating edge count, including the edge of the current cycle
    assign w_sat_hit   = w_edge && ((r_edge_cnt == CNT_MAX) || (r_edge_cnt == CNT_MAX - CNT_W'(1)));
    assign w_edge_next = (w_edge && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gate_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_next = ST_GATE;
            end
            ST_GATE: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_gate_cnt == GATE_LAST) begin
                    w_state_next = ST_DONE;
                    w_gate_end   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = enable ? ST_GATE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Window counters run only in GATE; held clear otherwise so each window starts fresh
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (r_state != ST_GATE) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_edge_next;
            r_sat      <= r_sat | w_sat_hit;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_freq_out   <= '0;
            r_freq_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_freq_valid <= w_gate_end;
            r_busy       <= (w_state_next == ST_GATE);
            if (w_gate_end) begin
                r_freq_out <= w_edge_next;
                r_overflow <= r_sat | w_sat_hit;
            end
        end
    end

    // Period path is independent of the gate FSM; first edge after enable only arms it
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_per_cnt      <= '0;
            r_armed        <= 1'b0;
            r_period_out   <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!enable) begin
                r_armed   <= 1'b0;
                r_per_cnt <= '0;
            end else if (w_edge) begin
                r_per_cnt <= PER_W'(1);
                r_armed   <= 1'b1;
                if (r_armed) begin
                    r_period_out   <= r_per_cnt;
                    r_period_valid <= 1'b1;
                end
            end else if (r_per_cnt != PER_MAX) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end
        end
    end

    assign freq_out     = r_freq_out;
    assign freq_valid   = r_freq_valid;
    assign overflow     = r_overflow;
    assign busy         = r_busy;
    assign period_out   = r_period_out;
    assign period_valid = r_period_valid;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: instance A (32-bit counters) and instance B (4-bit edge
// counter, 8-bit period counter), both with a 1000-cycle gate.
module tb_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, sig_a;
    logic [31:0] a_freq_out, a_period_out;
    logic        a_fv, a_pv, a_ovf, a_busy;

    logic        rst_b, en_b, sig_b;
    logic [3:0]  b_freq_out;
    logic [7:0]  b_period_out;
    logic        b_fv, b_pv, b_ovf, b_busy;

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(32), .PER_W(32)) dut_a (
        .clock_in(clk), .reset(rst_a), .enable(en_a), .sig_in(sig_a),
        .freq_out(a_freq_out), .freq_valid(a_fv), .period_out(a_period_out),
        .period_valid(a_pv), .overflow(a_ovf), .busy(a_busy)
    );

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(4), .PER_W(8)) dut_b (
        .clock_in(clk), .reset(rst_b), .enable(en_b), .sig_in(sig_b),
        .freq_out(b_freq_out), .freq_valid(b_fv), .period_out(b_period_out),
        .period_valid(b_pv), .overflow(b_ovf), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int half_a   = 0;
    int half_b   = 0;

    int          fv_cnt [2] = '{0, 0};
    int          fv_cyc [2] = '{0, 0};
    int          fv_prev[2] = '{0, 0};
    logic [31:0] fv_val [2] = '{32'd0, 32'd0};
    logic        fv_ovf [2] = '{1'b0, 1'b0};
    int          pv_cnt [2] = '{0, 0};
    logic [31:0] pv_val [2] = '{32'd0, 32'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_fv(input int ch, input int n);
        int target;
        int budget;
        target = fv_cnt[ch] + n;
        budget = 1100 * n + 200;
        while (fv_cnt[ch] < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (fv_cnt[ch] < target) check("fv_timeout", 64'(fv_cnt[ch]), 64'(target));
    endtask

    // Square-wave generators: toggle every half_x cycles; half_x == 0 holds the signal low
    initial begin : gen_a
        int g;
        g     = 0;
        sig_a = 1'b0;
        forever begin
            @(negedge clk);
            if (half_a == 0) begin
                g     = 0;
                sig_a = 1'b0;
            end else begin
                g++;
                if (g >= half_a) begin
                    g     = 0;
                    sig_a = ~sig_a;
                end
            end
        end
    end

    initial begin : gen_b
        int g;
        g     = 0;
        sig_b = 1'b0;
        forever begin
            @(negedge clk);
            if (half_b == 0) begin
                g     = 0;
                sig_b = 1'b0;
            end else begin
                g++;
                if (g >= half_b) begin
                    g     = 0;
                    sig_b = ~sig_b;
                end
            end
        end
    end

    // Output monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (a_fv) begin
            fv_prev[0] = fv_cyc[0];
            fv_cyc[0]  = cyc;
            fv_cnt[0]++;
            fv_val[0]  = a_freq_out;
            fv_ovf[0]  = a_ovf;
        end
        if (a_pv) begin
            pv_cnt[0]++;
            pv_val[0] = a_period_out;
        end
        if (b_fv) begin
            fv_prev[1] = fv_cyc[1];
            fv_cyc[1]  = cyc;
            fv_cnt[1]++;
            fv_val[1]  = 32'(b_freq_out);
            fv_ovf[1]  = b_ovf;
        end
        if (b_pv) begin
            pv_cnt[1]++;
            pv_val[1] = 32'(b_period_out);
        end
    end

    initial begin
        int c0;
        int base;
        rst_a = 1'b1;
        rst_b = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_freq_out",   64'(a_freq_out),   64'd0);
        check("rst_period_out", 64'(a_period_out), 64'd0);
        check("rst_busy",       64'(a_busy),       64'd0);
        check("rst_ovf",        64'(a_ovf),        64'd0);
        check("rst_valids",     64'({a_fv, a_pv}), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(a_busy), 64'd0);

        // Period 100, continuous windows
        en_a   = 1'b1;
        half_a = 50;
        c0     = cyc;
        @(negedge clk);
        check("busy_rise", 64'(a_busy), 64'd1);
        wait_fv(0, 1);
        check("first_win_lat", 64'(fv_cyc[0] - c0), 64'd1001);
        wait_fv(0, 2);
        check("freq_p100",    64'(fv_val[0]), 64'd10);
        check("ovf_p100",     64'(fv_ovf[0]), 64'd0);
        check("win_spacing",  64'(fv_cyc[0] - fv_prev[0]), 64'd1001);
        check("period_p100",  64'(pv_val[0]), 64'd100);

        // Period 500 from a known phase: first edge only arms the period path
        en_a   = 1'b0;
        half_a = 0;
        repeat (10) @(negedge clk);
        base   = pv_cnt[0];
        en_a   = 1'b1;
        half_a = 250;
        repeat (300) @(negedge clk);
        check("no_pv_first_edge", 64'(pv_cnt[0] - base), 64'd0);
        repeat (500) @(negedge clk);
        check("pv_second_edge", 64'(pv_cnt[0] - base), 64'd1);
        check("period_p500",    64'(pv_val[0]), 64'd500);
        wait_fv(0, 2);
        check("freq_p500", 64'(fv_val[0]), 64'd2);

        // Abort mid-window
        wait_fv(0, 1);
        repeat (500) @(negedge clk);
        check("busy_mid", 64'(a_busy), 64'd1);
        en_a = 1'b0;
        base = fv_cnt[0];
        @(negedge clk);
        check("busy_abort", 64'(a_busy), 64'd0);
        repeat (1500) @(negedge clk);
        check("no_fv_abort", 64'(fv_cnt[0] - base), 64'd0);
        check("freq_hold",   64'(a_freq_out), 64'd2);
        en_a = 1'b1;
        c0   = cyc;
        wait_fv(0, 1);
        check("restart_lat",  64'(fv_cyc[0] - c0), 64'd1001);
        check("restart_freq", 64'(fv_val[0]), 64'd2);

        // Asynchronous reset mid-window
        half_a = 50;
        wait_fv(0, 2);
        check("freq_back_p100", 64'(fv_val[0]), 64'd10);
        repeat (300) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("arst_freq_out",   64'(a_freq_out),   64'd0);
        check("arst_period_out", 64'(a_period_out), 64'd0);
        check("arst_ovf",        64'(a_ovf),        64'd0);
        check("arst_busy",       64'(a_busy),       64'd0);
        check("arst_valids",     64'({a_fv, a_pv}), 64'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        c0    = cyc;
        @(negedge clk);
        check("post_rst_busy", 64'(a_busy), 64'd1);
        wait_fv(0, 1);
        check("post_rst_lat",  64'(fv_cyc[0] - c0), 64'd1001);
        check("post_rst_freq", 64'(fv_val[0]), 64'd10);
        en_a = 1'b0;

        // Narrow counters: edge-count saturation then recovery
        en_b   = 1'b1;
        half_b = 2;
        wait_fv(1, 2);
        check("sat_freq",   64'(fv_val[1]), 64'd15);
        check("sat_ovf",    64'(fv_ovf[1]), 64'd1);
        check("period_p4",  64'(b_period_out), 64'd4);
        half_b = 50;
        wait_fv(1, 2);
        check("recover_freq", 64'(fv_val[1]), 64'd10);
        check("recover_ovf",  64'(fv_ovf[1]), 64'd0);

        // Period counter saturation, then a constant input
        half_b = 200;
        repeat (1300) @(negedge clk);
        check("period_sat",    64'(b_period_out), 64'd255);
        check("period_sat_pv", 64'(pv_val[1]),    64'd255);
        half_b = 0;
        repeat (5) @(negedge clk);
        base = pv_cnt[1];
        wait_fv(1, 2);
        check("const_freq",  64'(fv_val[1]), 64'd0);
        check("const_ovf",   64'(fv_ovf[1]), 64'd0);
        check("const_no_pv", 64'(pv_cnt[1] - base), 64'd0);
        en_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
